// File: rtl/vespa_int_ctrl.sv
// vespa_int_ctrl: prioritised interrupt controller with per-channel edge/level capture
// and a single-outstanding IDLE -> REQ -> SERVICE handshake towards the CPU.
module vespa_int_ctrl #(
    parameter int                 NUM_IRQ   = 4,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK = '1,
    parameter int                 RR_MODE   = 0,
    localparam int                IDX_W     = $clog2(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [NUM_IRQ-1:0] irq_mask,
    output logic               int_req,
    output logic [IDX_W-1:0]   int_number,
    input  logic               int_ack_attended,
    input  logic               int_ack_complete,
    output logic [NUM_IRQ-1:0] pending,
    output logic               busy
);
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    localparam logic [IDX_W:0]   NQ  = (IDX_W+1)'(NUM_IRQ);
    localparam logic [NUM_IRQ-1:0] ONE = NUM_IRQ'(1);

    state_t             state_q, state_d;
    logic [NUM_IRQ-1:0] sync1_q, sync2_q, prev_q, pending_q, pending_d;
    logic [NUM_IRQ-1:0] req_vec, clr, rot;
    logic [IDX_W-1:0]   int_number_q, int_number_d, rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   base, off, winner, next_ptr;
    logic [IDX_W:0]     sum, inc;
    logic               int_req_q, int_req_d, busy_q, busy_d;

    // Rotate the request vector so the search always starts at bit 0, then map back.
    always_comb begin
        req_vec = pending_q & irq_mask;
        base    = (RR_MODE != 0) ? rr_ptr_q : '0;
        rot     = NUM_IRQ'({req_vec, req_vec} >> base);
        off     = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (rot[i]) off = IDX_W'(i);
        sum      = {1'b0, base} + {1'b0, off};
        winner   = (sum >= NQ) ? IDX_W'(sum - NQ) : sum[IDX_W-1:0];
        inc      = {1'b0, int_number_q} + {{IDX_W{1'b0}}, 1'b1};
        next_ptr = (inc >= NQ) ? '0 : inc[IDX_W-1:0];
    end

    always_comb begin
        state_d      = state_q;
        int_req_d    = int_req_q;
        int_number_d = int_number_q;
        rr_ptr_d     = rr_ptr_q;
        clr          = '0;
        case (state_q)
            IDLE: if (|req_vec) begin
                state_d      = REQ;
                int_req_d    = 1'b1;
                int_number_d = winner;
            end
            REQ: if (int_ack_attended) begin
                state_d   = SERVICE;
                int_req_d = 1'b0;
                clr       = (ONE << int_number_q) & EDGE_MASK;
            end
            SERVICE: if (int_ack_complete) begin
                state_d  = IDLE;
                rr_ptr_d = next_ptr;
            end
            default: state_d = IDLE;
        endcase
        // A fresh edge wins over a same-cycle clear so no event is lost.
        pending_d = (EDGE_MASK & ((pending_q & ~clr) | (sync2_q & ~prev_q))) | (~EDGE_MASK & sync2_q);
        busy_d    = state_d != IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            prev_q       <= '0;
            pending_q    <= '0;
            state_q      <= IDLE;
            int_req_q    <= 1'b0;
            int_number_q <= '0;
            rr_ptr_q     <= '0;
            busy_q       <= 1'b0;
        end else begin
            sync1_q      <= irq_in;
            sync2_q      <= sync1_q;
            prev_q       <= sync2_q;
            pending_q    <= pending_d;
            state_q      <= state_d;
            int_req_q    <= int_req_d;
            int_number_q <= int_number_d;
            rr_ptr_q     <= rr_ptr_d;
            busy_q       <= busy_d;
        end
    end

    assign int_req    = int_req_q;
    assign int_number = int_number_q;
    assign pending    = pending_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_vespa_int_ctrl.sv
// tb_vespa_int_ctrl: directed and random checks of a fixed-priority all-edge instance
// and a round-robin mixed edge/level instance against a delay-line reference model.
module tb_vespa_int_ctrl;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] irq [2];
    logic [N-1:0] mask [2];
    logic         att [2];
    logic         cmp [2];
    logic         req0, req1, busy0, busy1;
    logic [1:0]   num0, num1;
    logic [N-1:0] pend0, pend1;

    int total = 0;
    int bad   = 0;
    int w;

    logic [N-1:0] edge_m [2] = '{4'b1111, 4'b1100};
    int           rr [2]     = '{0, 1};
    int           phase [2];
    int           num [2];
    int           ptr [2];
    logic [N-1:0] mpend [2];
    logic [N-1:0] h1 [2];
    logic [N-1:0] h2 [2];
    logic [N-1:0] h3 [2];

    always #5 clk = ~clk;

    vespa_int_ctrl #(.NUM_IRQ(N)) u_fix (
        .clk(clk), .rst(rst), .irq_in(irq[0]), .irq_mask(mask[0]),
        .int_req(req0), .int_number(num0),
        .int_ack_attended(att[0]), .int_ack_complete(cmp[0]),
        .pending(pend0), .busy(busy0)
    );

    vespa_int_ctrl #(.NUM_IRQ(N), .EDGE_MASK(4'b1100), .RR_MODE(1)) u_rr (
        .clk(clk), .rst(rst), .irq_in(irq[1]), .irq_mask(mask[1]),
        .int_req(req1), .int_number(num1),
        .int_ack_attended(att[1]), .int_ack_complete(cmp[1]),
        .pending(pend1), .busy(busy1)
    );

    function automatic bit has(logic [N-1:0] v, int k);
        return ((v >> k) & N'(1)) != '0;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            phase[m] = 0; num[m] = 0; ptr[m] = 0;
            mpend[m] = '0; h1[m] = '0; h2[m] = '0; h3[m] = '0;
        end
    endtask

    // h1/h2/h3 hold the input sampled one, two and three edges ago.
    task automatic model_edge();
        logic [N-1:0] ev, rq, clr;
        int base, k;
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                clr = '0;
                ev  = h2[m] & ~h3[m];
                rq  = mpend[m] & mask[m];
                if (phase[m] == 0 && rq != '0) begin
                    base = (rr[m] != 0) ? ptr[m] : 0;
                    for (int i = N - 1; i >= 0; i--) begin
                        k = (base + i) % N;
                        if (has(rq, k)) num[m] = k;
                    end
                    phase[m] = 1;
                end else if (phase[m] == 1 && att[m]) begin
                    phase[m] = 2;
                    if (has(edge_m[m], num[m])) clr = N'(1) << num[m];
                end else if (phase[m] == 2 && cmp[m]) begin
                    phase[m] = 0;
                    ptr[m]   = (num[m] + 1) % N;
                end
                mpend[m] = (edge_m[m] & ((mpend[m] & ~clr) | ev)) | (~edge_m[m] & h2[m]);
                h3[m] = h2[m];
                h2[m] = h1[m];
                h1[m] = irq[m];
            end
        end
    endtask

    task automatic check(int m, logic r, logic [1:0] n, logic [N-1:0] p, logic b);
        total++;
        assert (r === (phase[m] == 1)) else begin
            bad++; $error("FAIL int_req[%0d] got=%b exp=%b", m, r, phase[m] == 1);
        end
        total++;
        assert (b === (phase[m] != 0)) else begin
            bad++; $error("FAIL busy[%0d] got=%b exp=%b", m, b, phase[m] != 0);
        end
        total++;
        assert (p === mpend[m]) else begin
            bad++; $error("FAIL pending[%0d] got=%b exp=%b", m, p, mpend[m]);
        end
        if (phase[m] == 1) begin
            total++;
            assert (n === 2'(num[m])) else begin
                bad++; $error("FAIL int_number[%0d] got=%0d exp=%0d", m, n, num[m]);
            end
        end
    endtask

    task automatic check_all();
        check(0, req0, num0, pend0, busy0);
        check(1, req1, num1, pend1, busy1);
    endtask

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++; $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
    endtask

    task automatic attend(int m);
        att[m] = 1'b1; step(); att[m] = 1'b0;
    endtask

    task automatic complete(int m);
        cmp[m] = 1'b1; step(); cmp[m] = 1'b0;
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            irq[m] = '0; mask[m] = '1; att[m] = 1'b0; cmp[m] = 1'b0;
        end
        model_reset();
        #1 check_all();
        chk("rst_req", req0, 0);
        chk("rst_pend", pend0, 0);
        step(); step();
        rst = 1'b1;
        repeat (3) step();

        // single edge on channel 2: pending after k+2, request after k+3
        irq[0] = 4'b0100;
        step(); step(); step();
        chk("a_pend_k2", pend0, 4'b0100);
        chk("a_req_k2", req0, 0);
        step();
        chk("a_req_k3", req0, 1);
        chk("a_num_k3", num0, 2);
        attend(0); complete(0); irq[0] = '0; step();

        // channels 1 and 3 together: 1 first, then 3
        irq[0] = 4'b1010;
        repeat (4) step();
        chk("b_first", num0, 1);
        attend(0); complete(0); step();
        chk("b_second_req", req0, 1);
        chk("b_second", num0, 3);
        attend(0); complete(0); irq[0] = '0; step();

        // round-robin with two level channels
        irq[1] = 4'b0011;
        for (int r = 0; r < 4; r++) begin
            w = 0;
            while (!req1 && w < 10) begin step(); w++; end
            chk("c_req", req1, 1);
            chk("c_rr_num", num1, r % 2);
            attend(1); complete(1);
        end
        irq[1] = '0;
        repeat (3) step();

        // request held while its mask is removed
        irq[0] = 4'b0100;
        repeat (4) step();
        mask[0] = 4'b1011;
        repeat (3) begin
            step();
            chk("d_hold_req", req0, 1);
            chk("d_hold_num", num0, 2);
        end
        attend(0);
        chk("d_attended", req0, 0);
        complete(0); mask[0] = '1; irq[0] = '0; step();

        // new edge on channel 0 coinciding with its attend
        irq[0] = 4'b0001;
        repeat (4) step();
        chk("e_req", req0, 1);
        chk("e_num", num0, 0);
        irq[0] = '0; step();
        irq[0] = 4'b0001; step(); step();
        att[0] = 1'b1; step(); att[0] = 1'b0;
        chk("e_pend_kept", pend0[0], 1);
        complete(0); step();
        chk("e_rereq", req0, 1);
        chk("e_renum", num0, 0);
        attend(0); complete(0); irq[0] = '0; step();

        // asynchronous reset while in SERVICE
        irq[0] = 4'b0100;
        repeat (4) step();
        attend(0); irq[0] = '0;
        chk("f_busy_svc", busy0, 1);
        do_reset();
        chk("f_req", req0, 0);
        chk("f_num", num0, 0);
        chk("f_pend", pend0, 0);
        chk("f_busy", busy0, 0);
        step(); rst = 1'b1;
        repeat (8) begin
            step();
            chk("f_no_req", req0, 0);
        end

        // random traffic, masks, stray acks and occasional resets
        for (int c = 0; c < 1500; c++) begin
            for (int m = 0; m < 2; m++) begin
                if ($urandom_range(0, 3) == 0) irq[m] = N'($urandom);
                if ($urandom_range(0, 7) == 0) mask[m] = N'($urandom);
                att[m] = ($urandom_range(0, 2) == 0);
                cmp[m] = ($urandom_range(0, 2) == 0);
            end
            if ($urandom_range(0, 199) == 0) begin
                do_reset(); step(); rst = 1'b1;
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
